// File: rtl/schoolbook_sched.sv
// schoolbook_sched
//   Round-robin scheduler that shares one bit-serial schoolbook multiplier
//   (WIDTH x WIDTH, one partial product per cycle) among N_REQ requesters.
//   A granted operand pair is latched. The multiplier is sequenced through
//   clear (LOAD) and run (RUN) phases. The 2*WIDTH product is then returned
//   with the owning requester ID (RESP).
//
//   Optional build macro: SCHED_EARLY_EXIT_EN
//     When defined, RUN also ends once no set bits of B remain above the
//     current partial-product index. RUN therefore takes max(1, msb(B)+1) cycles.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester request valid              [N_REQ]
//   req_ready     per-requester accept, one-hot or zero    [N_REQ]
//   req_a, req_b  packed operands, lane i at [i*WIDTH +: WIDTH]
//   resp_valid    product valid
//   resp_ready    consumer accept
//   resp_id       requester index owning the product       [ID_W]
//   resp_c        product A*B                              [2*WIDTH]
//   mul_rst_n     active-low clear/enable to the multiplier
//   mul_a, mul_b  held operands to the multiplier          [WIDTH]
//   mul_c         multiplier accumulator                   [2*WIDTH]
//   busy          high whenever not IDLE
module schoolbook_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 283,
  parameter int unsigned CNT_W = 9,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_c,
  output logic                     mul_rst_n,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_c,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_hold_q, id_hold_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  logic [WIDTH-1:0] b_hold_q, b_hold_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             mul_rst_n_q, mul_rst_n_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  int unsigned      cand;
  int unsigned      grant_base;
  logic             run_last;

  // Rotating-priority search starting at rr_ptr. The wrap uses a subtract
  // instead of a modulo so that non-power-of-two N_REQ stays cheap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

`ifdef SCHED_EARLY_EXIT_EN
  // Stop once no set bit of B remains above the current index. The
  // accumulator already holds the full product at that point.
  always_comb begin
    run_last = (run_cnt_q == CNT_W'(WIDTH - 1)) ||
               ((b_hold_q >> (32'(run_cnt_q) + 32'd1)) == '0);
  end
`else
  always_comb begin
    run_last = (run_cnt_q == CNT_W'(WIDTH - 1));
  end
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_hold_d  = id_hold_q;
    run_cnt_d  = run_cnt_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    grant_base = 32'(grant_idx) * WIDTH;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_hold_d  = req_a[grant_base +: WIDTH];
          b_hold_d  = req_b[grant_base +: WIDTH];
          id_hold_d = grant_idx;
          rr_ptr_d  = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (run_last) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state. The multiplier enable
    // and response valid therefore come straight from flops.
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    mul_rst_n_d  = (state_d == RUN) || (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_hold_q    <= '0;
      run_cnt_q    <= '0;
      a_hold_q     <= '0;
      b_hold_q     <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mul_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_hold_q    <= id_hold_d;
      run_cnt_q    <= run_cnt_d;
      a_hold_q     <= a_hold_d;
      b_hold_q     <= b_hold_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      mul_rst_n_q  <= mul_rst_n_d;
    end
  end

  always_comb begin
    resp_valid = resp_valid_q;
    resp_id    = resp_valid_q ? id_hold_q : '0;
    resp_c     = resp_valid_q ? mul_c : '0;
    busy       = busy_q;
    mul_rst_n  = mul_rst_n_q;
    mul_a      = a_hold_q;
    mul_b      = b_hold_q;
  end

endmodule

// File: tb/tb_schoolbook_sched.sv
module tb_schoolbook_sched;
  localparam int N  = 4;
  localparam int W  = 283;
  localparam int CW = 9;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [IW-1:0]    resp_id;
  logic [2*W-1:0]   resp_c;
  logic             mul_rst_n;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_c;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  int model_ptr = 0;

  schoolbook_sched #(.N_REQ(N), .WIDTH(W), .CNT_W(CW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_c(resp_c), .mul_rst_n(mul_rst_n), .mul_a(mul_a),
    .mul_b(mul_b), .mul_c(mul_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared bit-serial multiplier: cleared while mul_rst_n
  // is low, then adds one partial product per cycle until its counter saturates.
  logic [2*W-1:0] acc;
  int unsigned    mcnt;
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      acc  <= '0;
      mcnt <= 0;
    end else if (mcnt < W) begin
      if (mul_b[mcnt]) acc <= acc + ({{W{1'b0}}, mul_a} << mcnt);
      mcnt <= mcnt + 1;
    end
  end
  assign mul_c = acc;

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  function automatic int run_len(input logic [W-1:0] b);
`ifdef SCHED_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return (msb < 0) ? 1 : msb + 1;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < (W + 31) / 32; k++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Drives one request and collects the grant vector, the cycles spent
  // waiting for the grant, the accept-to-response latency and the response.
  // The caller does all comparisons.
  task automatic do_txn(input logic [N-1:0] valid, input bit hold,
                        output logic [N-1:0] rdy, output int wait_cyc, output int lat,
                        output logic [2*W-1:0] c, output logic [IW-1:0] id, output bit to);
    to = 0; wait_cyc = 0; lat = 0; c = '0; id = '0; rdy = '0;
    req_valid = valid; resp_ready = 1'b1;
    #1;
    while (req_ready == '0 && wait_cyc < 50) begin
      @(negedge clk); #1; wait_cyc++;
    end
    rdy = req_ready;
    if (req_ready == '0) begin to = 1; return; end
    if (!hold) begin
      @(posedge clk); #1;
      req_valid = '0;
      for (int i = 0; i < N; i++) set_lane(i, rand_op(), rand_op());
    end
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < W + 10);
    if (!resp_valid) begin to = 1; return; end
    c = resp_c; id = resp_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vectors++; if (resp_id !== '0) begin miscompares++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    vectors++; if (mul_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_mul_rst_n: got %b expected 0", mul_rst_n); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (mul_a !== '0 || mul_b !== '0) begin miscompares++; $display("FAIL reset_mul_ops: got nonzero expected 0"); end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b0; model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] rdy; int wc, lat; logic [2*W-1:0] c; logic [IW-1:0] id; bit to;
    apply_reset();
    for (int i = 0; i < N; i++) set_lane(i, rand_op(), rand_op());
    set_lane(0, W'(3), W'(5));
    do_txn(4'b0001, 0, rdy, wc, lat, c, id, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b expected 0", to); end
    vectors++; if (rdy !== 4'b0001 || wc !== 0) begin miscompares++; $display("FAIL single_ready: got %b after %0d expected 0001 after 0", rdy, wc); end
    vectors++; if (lat !== run_len(W'(5)) + 2) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d", lat, run_len(W'(5)) + 2); end
    vectors++; if (c !== (2*W)'(15)) begin miscompares++; $display("FAIL single_product: got %0h expected f", c); end
    vectors++; if (id !== '0) begin miscompares++; $display("FAIL single_id: got %0d expected 0", id); end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rdy; int wc, lat, g; logic [2*W-1:0] c, e; logic [IW-1:0] id; bit to;
    logic [W-1:0] top;
    apply_reset();
    top = '0; top[W-1] = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i, W'(i + 1), top);
    for (int t = 0; t < 5; t++) begin
      g = exp_grant(4'b1111);
      e = (2*W)'(g + 1) << (W - 1);
      do_txn(4'b1111, 1, rdy, wc, lat, c, id, to);
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rr_timeout: txn %0d", t); end
      vectors++; if (rdy !== (4'b0001 << g)) begin miscompares++; $display("FAIL rr_grant: got %b expected %b", rdy, 4'b0001 << g); end
      vectors++; if (32'(id) !== g) begin miscompares++; $display("FAIL rr_id: got %0d expected %0d", id, g); end
      vectors++; if (c !== e) begin miscompares++; $display("FAIL rr_product: got %0h expected %0h", c, e); end
      vectors++; if (lat !== W + 2) begin miscompares++; $display("FAIL rr_latency: got %0d expected %0d", lat, W + 2); end
      if (t > 0) begin
        vectors++; if (wc !== 0) begin miscompares++; $display("FAIL rr_spacing: got %0d wait cycles expected 0", wc); end
      end
      model_ptr = (g + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_all_ones();
    logic [N-1:0] rdy; int wc, lat; logic [2*W-1:0] c, e, one; logic [IW-1:0] id; bit to;
    apply_reset();
    set_lane(1, '1, '1);
    one = (2*W)'(1);
    e = '0 - (one << (W + 1)) + one;
    do_txn(4'b0010, 0, rdy, wc, lat, c, id, to);
    vectors++; if (to !== 1'b0 || rdy !== 4'b0010) begin miscompares++; $display("FAIL ones_grant: got %b expected 0010", rdy); end
    vectors++; if (c !== e) begin miscompares++; $display("FAIL ones_product: got %0h expected %0h", c, e); end
    vectors++; if (id !== IW'(1) || lat !== W + 2) begin miscompares++; $display("FAIL ones_id_lat: got %0d/%0d expected 1/%0d", id, lat, W + 2); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b; logic [2*W-1:0] cap; int n;
    apply_reset();
    a = rand_op(); b = rand_op();
    set_lane(0, a, b);
    req_valid = 4'b0001; resp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    n = 0;
    while (!resp_valid && n < W + 10) begin @(negedge clk); n++; end
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_timeout: got %b expected 1", resp_valid); end
    cap = resp_c;
    vectors++; if (cap !== prod(a, b) || resp_id !== '0) begin miscompares++; $display("FAIL bp_product: got %0h expected %0h", cap, prod(a, b)); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_c !== cap || resp_id !== '0 || req_ready !== '0) begin
        miscompares++; $display("FAIL bp_hold: cycle %0d valid %b id %0d ready %b", k, resp_valid, resp_id, req_ready);
      end
    end
    resp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL bp_ready_in_resp: got %b expected 0", req_ready); end
    @(negedge clk); #1;
    vectors++; if (req_ready !== 4'b0010 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_next_grant: got %b/%b expected 0010/0", req_ready, resp_valid); end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] rdy; int wc, lat, seen; logic [2*W-1:0] c; logic [IW-1:0] id; bit to;
    logic [W-1:0] a, b;
    apply_reset();
    set_lane(2, rand_op(), rand_op());
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL mr_grant: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (101) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || mul_rst_n !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_running: busy %b mul_rst_n %b resp_valid %b expected 1/1/0", busy, mul_rst_n, resp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || mul_rst_n !== 1'b0) begin miscompares++; $display("FAIL mr_abort: busy %b mul_rst_n %b expected 0/0", busy, mul_rst_n); end
    @(negedge clk);
    rst = 1'b0; model_ptr = 0;
    seen = 0;
    for (int k = 0; k < W + 10; k++) begin @(negedge clk); if (resp_valid) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mr_no_resp: got %0d valid cycles expected 0", seen); end
    a = rand_op(); b = rand_op();
    for (int i = 0; i < N; i++) set_lane(i, a, b);
    do_txn(4'b1111, 0, rdy, wc, lat, c, id, to);
    vectors++; if (to !== 1'b0 || rdy !== 4'b0001 || id !== '0) begin miscompares++; $display("FAIL mr_ptr: got %b id %0d expected 0001 id 0", rdy, id); end
    vectors++; if (c !== prod(a, b)) begin miscompares++; $display("FAIL mr_product: got %0h expected %0h", c, prod(a, b)); end
  endtask

  task automatic test_early_exit();
    logic [N-1:0] rdy; int wc, lat; logic [2*W-1:0] c; logic [IW-1:0] id; bit to;
    apply_reset();
    set_lane(0, W'(7), W'(6));
    do_txn(4'b0001, 0, rdy, wc, lat, c, id, to);
    vectors++; if (to !== 1'b0 || lat !== run_len(W'(6)) + 2) begin miscompares++; $display("FAIL ee_lat6: got %0d expected %0d", lat, run_len(W'(6)) + 2); end
    vectors++; if (c !== (2*W)'(42)) begin miscompares++; $display("FAIL ee_prod42: got %0h expected 2a", c); end
    set_lane(1, rand_op(), '0);
    do_txn(4'b0010, 0, rdy, wc, lat, c, id, to);
    vectors++; if (to !== 1'b0 || lat !== run_len('0) + 2) begin miscompares++; $display("FAIL ee_lat0: got %0d expected %0d", lat, run_len('0) + 2); end
    vectors++; if (c !== '0 || id !== IW'(1)) begin miscompares++; $display("FAIL ee_prod0: got %0h id %0d expected 0 id 1", c, id); end
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, v; int wc, lat, g; logic [2*W-1:0] c; logic [IW-1:0] id; bit to;
    logic [W-1:0] as [N]; logic [W-1:0] bs [N];
    apply_reset();
    for (int t = 0; t < 12; t++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        as[i] = rand_op();
        bs[i] = rand_op() >> $urandom_range(0, W);
        set_lane(i, as[i], bs[i]);
      end
      g = exp_grant(v);
      do_txn(v, 0, rdy, wc, lat, c, id, to);
      vectors++; if (to !== 1'b0 || rdy !== (4'b0001 << g) || 32'(id) !== g) begin miscompares++; $display("FAIL rand_grant: txn %0d got %b id %0d expected grant %0d", t, rdy, id, g); end
      vectors++; if (c !== prod(as[g], bs[g])) begin miscompares++; $display("FAIL rand_product: txn %0d got %0h expected %0h", t, c, prod(as[g], bs[g])); end
      vectors++; if (lat !== run_len(bs[g]) + 2) begin miscompares++; $display("FAIL rand_latency: txn %0d got %0d expected %0d", t, lat, run_len(bs[g]) + 2); end
      model_ptr = (g + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_all_ones();
    test_backpressure();
    test_mid_reset();
    test_early_exit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
